// File: rtl/sign_narrower.sv
// Narrows signed IN_W-bit words to signed OUT_W-bit immediates through one
// registered valid/ready stage, flagging (and optionally clamping) values that do not fit.
module sign_narrower #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 4,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clear_stat
);

  // Bits in_data[IN_W-2:OUT_W-1] must each match the sign bit for the value to fit.
  localparam int CMP_W = IN_W - OUT_W;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CMP_W-1:0] bit_agree;
  logic             representable;
  logic             ovf_next;
  logic [OUT_W-1:0] data_next;
  logic             accept;
  logic             ovf_event;

  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             out_ovf_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             sticky_reg;
  logic             sticky_next;

  genvar gi;
  generate
    for (gi = 0; gi < CMP_W; gi++) begin : g_agree
      assign bit_agree[gi] = in_data[OUT_W-1+gi] ~^ in_data[IN_W-1];
    end
  endgenerate

  assign representable = &bit_agree;

  always_comb begin
    ovf_next  = !representable;
    data_next = in_data[OUT_W-1:0];
    if (SATURATE && ovf_next) begin
      data_next = in_data[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Ready is forced low while reset is held so nothing is accepted into a cleared stage.
  assign in_ready  = reset_n && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign ovf_event = accept && ovf_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= data_next;
      out_ovf_reg   <= ovf_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // A clear that coincides with an overflow keeps that overflow as the first new event.
  always_comb begin
    count_next  = count_reg;
    sticky_next = sticky_reg;
    if (clear_stat) begin
      count_next  = ovf_event ? CNT_ONE : '0;
      sticky_next = ovf_event;
    end else if (ovf_event) begin
      sticky_next = 1'b1;
      if (count_reg != CNT_MAX) begin
        count_next = count_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= '0;
      sticky_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      sticky_reg <= sticky_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_ovf    = out_ovf_reg;
  assign ovf_count  = count_reg;
  assign ovf_sticky = sticky_reg;

endmodule

// File: doc/sign_narrower.md
Name: sign_narrower

Overview:
- Inverse of the datapath's 4-to-16 sign extension: narrows 16-bit two's-complement values to 4-bit signed immediates.
- Sits between the operand/ALU result path and the immediate-field packer.
- Flags values not representable in 4 bits, and optionally saturates them.
- Single pipeline register with valid/ready handshakes on both sides, plus a saturating overflow-event counter and a sticky flag.

Parameters:
- IN_W, 16, input word width (bits).
- OUT_W, 4, output immediate width (bits); must satisfy 2 <= OUT_W < IN_W.
- SATURATE, 1: 1 = clamp out-of-range values to the max/min OUT_W value; 0 = plain truncation to the low OUT_W bits.
- CNT_W, 8, overflow counter width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a word to narrow.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  IN_W  signed input word.
- out_valid  output  1  out_data/out_ovf hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  OUT_W  narrowed signed immediate.
- out_ovf  output  1  input was not representable in OUT_W bits.
- ovf_sticky  output  1  set by any accepted overflowing word; cleared only by clear_stat.
- ovf_count  output  CNT_W  number of accepted overflowing words, saturating.
- clear_stat  input  1  synchronous clear of ovf_count and ovf_sticky.

Behaviour:
- Reset is asynchronous and active-low, on clk/reset_n. While reset_n=0, all outputs are 0: out_valid, out_data, out_ovf, ovf_sticky, ovf_count. in_ready is 0 during reset and 1 in the first cycle after release.
- in_ready = !out_valid || out_ready. This is combinational from out_ready and allows full throughput.
- Accept: in_valid && in_ready at a rising edge. The result is registered and out_valid=1 in the next cycle, giving 1-cycle latency.
- Hold: while out_valid && !out_ready, out_data and out_ovf stay stable and no new word is accepted.
- out_valid drops only after out_valid && out_ready with no simultaneous accept. Simultaneous consume and accept replaces the result with no bubble.
- Representable iff in_data[IN_W-1:OUT_W-1] are all equal.
- If representable: out_data = in_data[OUT_W-1:0] and out_ovf = 0.
- If not representable: out_ovf = 1.
  - SATURATE=1: out_data = 0111 if in_data[IN_W-1]=0, else 1000 (i.e. max/min of OUT_W).
  - SATURATE=0: out_data = in_data[OUT_W-1:0].
- Round-trip invariant: sign-extending out_data back to IN_W equals in_data whenever out_ovf=0.
- ovf_count:
  - Increments by 1 on each accepted overflowing word.
  - Holds at 2^CNT_W-1 and does not wrap.
  - clear_stat alone sets it to 0.
  - clear_stat in the same cycle as an accepted overflowing word sets it to 1; the event is not lost.
- ovf_sticky follows the same set/clear rule as ovf_count (becomes 1 if clear and overflow coincide).
- Counters and flag change only on accepts, never on output consumption.
- Reset mid-transfer: any pending result is discarded with no output handshake. The first accept after reset release behaves as from idle.
- No X propagation: out_data must be driven from registers only, never directly from in_data.

Test Plan:
- Reset, then present 0x0005, 0xFFFD, 0x0007, 0xFFF8 back-to-back with out_ready=1 -> out_data 5, D, 7, 8 on consecutive cycles; out_ovf=0 throughout; ovf_count=0; one result per cycle.
- SATURATE=1: inputs 0x0008, 0x7FFF, 0xFFF7, 0x8000 -> out_data 7, 7, 8, 8; out_ovf=1 each; ovf_count=4; ovf_sticky=1. SATURATE=0 with the same inputs -> out_data 8, F, 7, 0.
- Backpressure: accept 0x0003, hold out_ready=0 for 3 cycles while in_valid=1 with 0x0002 -> in_ready=0 and out_data stays 3. Raise out_ready -> 3 consumed, 2 appears the next cycle, nothing dropped or duplicated.
- Counter edges (CNT_W=8): 300 overflowing words -> ovf_count stops at 255. Then clear_stat alone -> 0. Then clear_stat together with an accepted 0x0100 -> ovf_count=1 and ovf_sticky=1.
- Assert reset_n=0 asynchronously (mid-cycle) while out_valid=1 and out_ready=0 -> all outputs 0 immediately. After release, in_ready=1 and the next word 0x0001 yields out_data=1 after 1 cycle.
- Random 16-bit stream with random out_ready -> a scoreboard checks in-order delivery, the round-trip invariant when out_ovf=0, and ovf_count equal to a reference count.
